// File: rtl/shared_mem_arb_pkg.sv
// Shared types, widths and helpers for shared_mem_arbiter.
// Request index ports carry one spare bit so out-of-range words/lanes can be expressed.
package shared_mem_arb_pkg;

   // Width of an index into n items, at least one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int SMA_NREQ  = 3;
   localparam int SMA_DEPTH = 8;
   localparam int SMA_WIDTH = 32;
   localparam int SMA_SLICE = 8;
   localparam int SMA_LANES = SMA_WIDTH / SMA_SLICE;
   localparam int SMA_AW    = idx_w(SMA_DEPTH) + 1;
   localparam int SMA_OW    = idx_w(SMA_LANES) + 1;
   localparam int SMA_PW    = idx_w(SMA_NREQ);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic                  we;
      logic [SMA_AW-1:0]     addr;
      logic [SMA_OW-1:0]     off;
      logic [SMA_SLICE-1:0]  wdata;
   } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);

   // Scan N positions starting at ptr; the first valid one wins.
   always_comb begin
      logic [PW-1:0] j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int k = 0; k < N; k++) begin
         j = PW'((int'(ptr) + k) % N);
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one word memory among NREQ slice-granular requesters.
// Optional grant locking is built when SHARED_MEM_ARB_LOCK_EN is defined.
// Handshake: a transfer happens on a clock edge where req_valid[i] && req_ready[i];
// the requester holds every req_* field stable until then, and the registered
// one-hot rsp_valid pulses for exactly one cycle after the transfer.
module shared_mem_arbiter
   import shared_mem_arb_pkg::*;
#(
   parameter  int NREQ  = SMA_NREQ,
   parameter  int DEPTH = SMA_DEPTH,
   parameter  int WIDTH = SMA_WIDTH,
   parameter  int SLICE = SMA_SLICE,
   localparam int LANES = WIDTH / SLICE,
   localparam int AW    = idx_w(DEPTH) + 1,
   localparam int OW    = idx_w(LANES) + 1,
   localparam int PW    = idx_w(NREQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0]            req_we,
   input  logic [NREQ-1:0][AW-1:0]    req_addr,
   input  logic [NREQ-1:0][OW-1:0]    req_off,
   input  logic [NREQ-1:0][SLICE-1:0] req_wdata,
   input  logic [NREQ-1:0]            req_lock,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [SLICE-1:0]           rsp_rdata,
   output logic                       rsp_err,
   output arb_state_e                 dbg_state,
   output logic [PW-1:0]              dbg_rr_ptr
);

   localparam int IW = idx_w(DEPTH);
   localparam int LW = idx_w(LANES);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    gidx;
   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  grant;
   logic             xfer;
   logic             in_range;
   logic [IW-1:0]    widx;
   logic [LW-1:0]    woff;
   arb_state_e       state;
   req_t             sel;

`ifdef SHARED_MEM_ARB_LOCK_EN
   arb_state_e    state_n;
   logic [PW-1:0] owner;
   logic [PW-1:0] owner_n;

   // While locked only the owner may compete.
   assign elig = (state == LOCKED) ? (req_valid & (NREQ'(1) << owner)) : req_valid;

   // Lock state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
      end else begin
         state <= state_n;
         owner <= owner_n;
      end
   end

   // Enter LOCKED on a locking transfer; leave on an unlocking transfer or an idle owner cycle.
   always_comb begin
      state_n = state;
      owner_n = owner;
      case (state)
         IDLE: begin
            if (xfer && req_lock[gidx]) begin
               state_n = LOCKED;
               owner_n = gidx;
            end
         end
         LOCKED: begin
            if (!req_valid[owner])
               state_n = IDLE;
            else if (xfer && !req_lock[owner])
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign state       = IDLE;
   assign elig        = req_valid;
`endif

   rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
      .req   (elig & {NREQ{~rst}}),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (xfer)
   );

   assign req_ready  = grant;
   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

   // Route the winning requester's fields and decode its range.
   always_comb begin
      sel.we    = req_we[gidx];
      sel.addr  = req_addr[gidx];
      sel.off   = req_off[gidx];
      sel.wdata = req_wdata[gidx];
      in_range  = (int'(sel.addr) < DEPTH) && (int'(sel.off) < LANES);
      widx      = sel.addr[IW-1:0];
      woff      = sel.off[LW-1:0];
   end

   // Round-robin pointer moves past the winner, but stays frozen while locked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (xfer && state == IDLE)
         rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
   end

   // Storage is not reset; only in-range writes touch one slice of one word.
   always_ff @(posedge clk) begin
      if (xfer && sel.we && in_range)
         mem[widx][woff*SLICE +: SLICE] <= sel.wdata;
   end

   // Registered one-cycle response to the granted requester.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= xfer ? grant : '0;
         rsp_err   <= xfer && !in_range;
         rsp_rdata <= (xfer && in_range && !sel.we) ? mem[widx][woff*SLICE +: SLICE] : '0;
      end
   end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed scenarios plus randomized traffic,
// with expected responses queued at grant time and checked by a monitor.
module tb_shared_mem_arbiter;
   import shared_mem_arb_pkg::*;

   localparam int N     = SMA_NREQ;
   localparam int DEPTH = SMA_DEPTH;
   localparam int LANES = SMA_LANES;
   localparam int SL    = SMA_SLICE;
   localparam int AW    = SMA_AW;
   localparam int OW    = SMA_OW;
   localparam int PW    = SMA_PW;
   localparam int RW    = N + 1 + SL;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]          req_valid, req_ready, req_we, req_lock, rsp_valid;
   logic [N-1:0][AW-1:0]  req_addr;
   logic [N-1:0][OW-1:0]  req_off;
   logic [N-1:0][SL-1:0]  req_wdata;
   logic [SL-1:0]         rsp_rdata;
   logic                  rsp_err;
   arb_state_e            dbg_state;
   logic [PW-1:0]         dbg_rr_ptr;

   shared_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_off(req_off), .req_wdata(req_wdata),
      .req_lock(req_lock), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   logic [RW-1:0] exp_q[$];
   int grants[$];

   // pending request per requester (held until granted)
   bit           p_v[N];
   bit           p_we[N];
   int           p_addr[N];
   int           p_off[N];
   logic [SL-1:0] p_wd[N];
   bit           p_lock[N];

   // reference model: slice-addressed memory, rotating priority, lock owner
   logic [SL-1:0] m_mem[DEPTH][LANES];
   int  m_ptr = 0;
   bit  m_locked = 0;
   int  m_owner = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic issue(input int r, input bit we, input int a, input int o,
                        input logic [SL-1:0] d, input bit lk);
      p_v[r] = 1; p_we[r] = we; p_addr[r] = a; p_off[r] = o; p_wd[r] = d; p_lock[r] = lk;
   endtask

   function automatic int model_pick();
      if (m_locked) return p_v[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++)
         if (p_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   // ---------------- driver: one cycle ----------------
   task automatic step();
      int g;
      bit was_locked;
      bit owner_v;
      bit lk;
      bit err;
      logic [SL-1:0] rd;
      logic [N-1:0] oh;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         req_valid[i] = p_v[i];
         req_we[i]    = p_we[i];
         req_addr[i]  = AW'(p_addr[i]);
         req_off[i]   = OW'(p_off[i]);
         req_wdata[i] = p_wd[i];
         req_lock[i]  = p_lock[i];
      end
      #1;
      g = model_pick();
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      check("req_ready", req_ready, oh);
      was_locked = m_locked;
      owner_v = p_v[m_owner];
      lk = (g >= 0) ? p_lock[g] : 1'b0;
      if (g >= 0) begin
         err = (p_addr[g] >= DEPTH) || (p_off[g] >= LANES);
         rd  = '0;
         if (!err) begin
            if (p_we[g]) m_mem[p_addr[g]][p_off[g]] = p_wd[g];
            else         rd = m_mem[p_addr[g]][p_off[g]];
         end
         exp_q.push_back({oh, err, rd});
         if (!was_locked) m_ptr = (g + 1) % N;
         grants.push_back(g);
         p_v[g] = 0;
      end
`ifdef SHARED_MEM_ARB_LOCK_EN
      if (was_locked) begin
         if (!owner_v) m_locked = 0;
         else if (g == m_owner && !lk) m_locked = 0;
      end else if (g >= 0 && lk) begin
         m_locked = 1;
         m_owner  = g;
      end
`else
      lk = lk & owner_v;
`endif
   endtask

   task automatic drain(input int max_cycles);
      int c = 0;
      bit busy = 1;
      while (busy && c < max_cycles) begin
         busy = 0;
         for (int i = 0; i < N; i++) busy |= p_v[i];
         if (busy) begin step(); c++; end
      end
      if (busy) begin
         n_cmp++; n_fail++;
         $display("FAIL drain_timeout: requests still pending after %0d cycles", max_cycles);
         for (int i = 0; i < N; i++) p_v[i] = 0;
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [RW-1:0] e;
      forever begin
         @(negedge clk);
         if (rsp_valid !== '0 || exp_q.size() != 0) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            check("rsp", {rsp_valid, rsp_err, rsp_rdata}, e);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] w;
      int seq_rr[6];
      int seq_lk[6];
      seq_rr = '{0, 1, 2, 0, 1, 2};
      seq_lk = '{1, 1, 1, 1, 2, 0};
      for (int i = 0; i < N; i++) issue(i, 0, 0, 0, '0, 0);
      for (int i = 0; i < N; i++) p_v[i] = 0;
      req_valid = '1; req_we = '0; req_lock = '0;
      req_addr = '0; req_off = '0; req_wdata = '0;

      // reset values while reset is held, with all requesters valid
      repeat (2) @(negedge clk);
      check("rst_ready", req_ready, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rdata", rsp_rdata, '0);
      check("rst_err", rsp_err, 1'b0);
      check("rst_ptr", dbg_rr_ptr, '0);
      check("rst_state", dbg_state, IDLE);
      req_valid = '0;
      rst = 1'b0;

      // all three continuously valid from reset: strict rotation
      grants.delete();
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++)
            if (!p_v[i]) issue(i, 1, i, 0, SL'($urandom), 0);
         step();
      end
      for (int i = 0; i < N; i++) p_v[i] = 0;
      check("rr_count", grants.size(), 6);
      for (int i = 0; i < 6; i++) check("rr_order", grants[i], seq_rr[i]);

      // fill memory; word 2 gets 32'h11223344
      for (int a = 0; a < DEPTH; a++)
         for (int o = 0; o < LANES; o++) begin
            w = 32'h11223344;
            issue(0, 1, a, o, (a == 2) ? w[o*8 +: 8] : SL'($urandom), 0);
            drain(4);
         end

      // slice write then read, neighbours untouched
      issue(0, 1, 2, 1, 8'hA5, 0); drain(4);
      issue(0, 0, 2, 1, '0, 0);    drain(4);
      for (int o = 0; o < LANES; o++) begin issue(0, 0, 2, o, '0, 0); drain(4); end

      // out-of-range accesses: error response, memory unchanged
      issue(0, 0, 9, 0, '0, 0);     drain(4);
      issue(1, 1, 3, 5, 8'hFF, 0);  drain(4);
      issue(2, 1, 8, 4, 8'hEE, 0);  drain(4);
      for (int o = 0; o < LANES; o++) begin issue(2, 0, 3, o, '0, 0); drain(4); end

      // back-to-back write by 2 then read by 0 of the same slice
      issue(2, 1, 5, 3, 8'h3C, 0); step();
      issue(0, 0, 5, 3, '0, 0);    step();

      // reset right after a read transfer drops its response
      issue(1, 0, 4, 0, '0, 0); step();
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = '0;
      exp_q.delete();
      m_ptr = 0; m_locked = 0;
      @(negedge clk);
      check("rst_drop_rsp", rsp_valid, '0);
      rst = 1'b0;
      #1;
      check("rst_ptr_after", dbg_rr_ptr, '0);
      check("rst_state_after", dbg_state, IDLE);
      issue(0, 0, 1, 1, '0, 0);
      issue(2, 0, 1, 2, '0, 0);
      step();
      check("rst_winner", req_ready, 3'b001);
      drain(6);

`ifdef SHARED_MEM_ARB_LOCK_EN
      // requester 1 locks against 0 and 2
      grants.delete();
      issue(1, 1, 6, 0, 8'h10, 1); step();
      issue(0, 0, 6, 0, '0, 0);
      issue(2, 0, 6, 1, '0, 0);
      for (int n = 1; n < 4; n++) begin
         issue(1, 1, 6, n, SL'(8'h10 + n), n < 3);
         step();
         if (n == 1) check("lock_state", dbg_state, LOCKED);
      end
      drain(6);
      check("lock_count", grants.size(), 6);
      for (int i = 0; i < 6; i++) check("lock_order", grants[i], seq_lk[i]);
`endif

      // randomized mixed traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!p_v[i] && $urandom_range(0, 1) == 1)
               issue(i, $urandom_range(0, 1) == 1, $urandom_range(0, 9),
                     $urandom_range(0, 4), SL'($urandom), $urandom_range(0, 3) == 0);
         step();
      end
      drain(60);

      step();
      step();
      @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
